// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// default start-of-frame byte and the checksum step.
package m_imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_COUNT = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_CSUM  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/m_imem_loader_word_assembler.sv
// Byte-to-word packer: collects four bytes LSB first and flags the byte that
// completes a word, presenting the full little-endian word in that same cycle.
module m_word_assembler (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);

  logic [1:0]  r_lane;
  logic [23:0] r_word;

  // Lane counter and the three lower lanes; lane 3 is taken straight from the input.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_lane <= 2'd0;
      r_word <= 24'd0;
    end else if (i_clr) begin
      r_lane <= 2'd0;
      r_word <= 24'd0;
    end else if (i_valid) begin
      case (r_lane)
        2'd0:    r_word[7:0]   <= i_byte;
        2'd1:    r_word[15:8]  <= i_byte;
        2'd2:    r_word[23:16] <= i_byte;
        default: r_word        <= r_word;
      endcase
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_complete = i_valid & (r_lane == 2'd3);
  assign o_word     = {i_byte, r_word};

endmodule

// File: rtl/m_imem_loader.sv
// Boot-time writer for imem: parses MAGIC/N/data/CSUM frames, writes one word per
// cycle and releases the processor hold only after a frame with a good checksum.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int         DEPTH  = 64,
  parameter int         ADDR_W = 6,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rx_valid,
  input  logic [7:0]        w_rx_byte,
  output logic              w_rx_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_waddr,
  output logic [31:0]       w_wdata,
  output logic              w_cpu_hold,
  output logic              w_done,
  output logic              w_err
);

  localparam logic [8:0]    DEPTH_L = 9'(DEPTH);
  localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_rx_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W:0]     r_word_cnt;
  logic [7:0]          r_csum;

  logic                w_xfer;
  logic                w_asm_valid;
  logic                w_asm_clr;
  logic [31:0]         w_asm_word;
  logic                w_asm_complete;
  logic                w_count_bad;
  logic                w_last_word;

  assign w_xfer      = w_rx_valid & r_rx_ready;
  assign w_asm_valid = w_xfer & (r_state == ST_DATA);
  assign w_asm_clr   = w_xfer & (r_state == ST_COUNT);
  assign w_count_bad = (w_rx_byte == 8'd0) || ({1'b0, w_rx_byte} > DEPTH_L);
  assign w_last_word = (r_word_cnt + W_ONE) == r_n;

  m_word_assembler u_asm (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .i_clr      (w_asm_clr),
    .i_valid    (w_asm_valid),
    .i_byte     (w_rx_byte),
    .o_word     (w_asm_word),
    .o_complete (w_asm_complete)
  );

  // Frame FSM, counters, checksum and the registered imem write port.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state    <= ST_IDLE;
      r_rx_ready <= 1'b1;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_n        <= '0;
      r_word_cnt <= '0;
      r_csum     <= 8'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && (w_rx_byte == MAGIC)) begin
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (w_xfer) begin
            if (w_count_bad) begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_rx_ready <= 1'b0;
            end else begin
              r_n        <= w_rx_byte[ADDR_W:0];
              r_word_cnt <= '0;
              r_csum     <= 8'd0;
              r_state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_csum <= csum_next(r_csum, w_rx_byte);
            if (w_asm_complete) begin
              r_we       <= 1'b1;
              r_waddr    <= r_word_cnt[ADDR_W-1:0];
              r_wdata    <= w_asm_word;
              r_word_cnt <= r_word_cnt + W_ONE;
              if (w_last_word) begin
                r_state <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_rx_ready <= 1'b0;
            if (w_rx_byte == r_csum) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_rx_ready <= 1'b0;
        end
        ST_ERR: begin
          r_rx_ready <= 1'b0;
        end
        default: begin
          // An unreachable encoding parks in ERR with the processor still held.
          r_state    <= ST_ERR;
          r_err      <= 1'b1;
          r_rx_ready <= 1'b0;
          r_cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  assign w_rx_ready = r_rx_ready;
  assign w_we       = r_we;
  assign w_waddr    = r_waddr;
  assign w_wdata    = r_wdata;
  assign w_cpu_hold = r_cpu_hold;
  assign w_done     = r_done;
  assign w_err      = r_err;

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: expected imem writes go to a scoreboard queue
// when data bytes are driven and are checked as each w_we pulse appears.
module tb_m_imem_loader;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_rx_valid = 1'b0;
  logic [7:0] w_rx_byte = 8'd0;
  logic       w_rx_ready;
  logic       w_we;
  logic [5:0] w_waddr;
  logic [31:0] w_wdata;
  logic       w_cpu_hold;
  logic       w_done;
  logic       w_err;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cycle = 0;
  int  we_count = 0;
  int  prev_we_cycle = -1;
  bit  chk_gap = 1'b0;
  logic [31:0] words[64];

  m_imem_loader dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_rx_valid (w_rx_valid),
    .w_rx_byte  (w_rx_byte),
    .w_rx_ready (w_rx_ready),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_cpu_hold (w_cpu_hold),
    .w_done     (w_done),
    .w_err      (w_err)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) cycle++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the scoreboard.
  always @(negedge w_clk) begin
    if (w_we === 1'b1) begin
      wr_t e;
      we_count++;
      chk("we_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      chk("done_before_last_we", {31'd0, w_done}, 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("waddr", {26'd0, w_waddr}, {26'd0, e.addr});
        chk("wdata", w_wdata, e.data);
      end
      if (chk_gap && prev_we_cycle >= 0)
        chk("we_spacing", cycle - prev_we_cycle, 32'd4);
      prev_we_cycle = cycle;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int t = 0;
    w_rx_valid = 1'b1;
    w_rx_byte  = b;
    while (!acc && t < 50) begin
      acc = w_rx_ready;
      @(posedge w_clk);
      #1;
      t++;
    end
    w_rx_valid = 1'b0;
    chk("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    w_rx_valid = 1'b0;
    idle(2);
    w_rst = 1'b0;
    prev_we_cycle = -1;
  endtask

  task automatic check_reset_values();
    chk("rst_ready", {31'd0, w_rx_ready}, 32'd1);
    chk("rst_we", {31'd0, w_we}, 32'd0);
    chk("rst_waddr", {26'd0, w_waddr}, 32'd0);
    chk("rst_wdata", w_wdata, 32'd0);
    chk("rst_hold", {31'd0, w_cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, w_done}, 32'd0);
    chk("rst_err", {31'd0, w_err}, 32'd0);
  endtask

  // Sends MAGIC, n, the first n entries of words[] and a checksum XOR-ed with csum_flip.
  task automatic send_frame(input int n, input logic [7:0] csum_flip, input bit gaps);
    logic [7:0] cs = 8'd0;
    logic [31:0] wd;
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      wd = words[k];
      sb.push_back('{addr: 6'(k), data: wd});
      for (int l = 0; l < 4; l++) begin
        if (gaps) idle($urandom_range(0, 2));
        send_byte(wd[8*l +: 8]);
        cs = cs ^ wd[8*l +: 8];
      end
    end
    if (gaps) idle($urandom_range(0, 2));
    send_byte(cs ^ csum_flip);
  endtask

  task automatic check_end(input string tag, input bit good, input int exp_we);
    idle(2);
    chk({tag, "_done"}, {31'd0, w_done}, {31'd0, good});
    chk({tag, "_hold"}, {31'd0, w_cpu_hold}, {31'd0, ~good});
    chk({tag, "_err"}, {31'd0, w_err}, {31'd0, ~good});
    chk({tag, "_ready"}, {31'd0, w_rx_ready}, 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    chk({tag, "_we_count"}, we_count, exp_we);
  endtask

  initial begin
    idle(2);
    check_reset_values();
    w_rst = 1'b0;
    idle(1);

    // 1: good one-word frame
    words[0] = 32'h00100513;
    we_count = 0;
    send_frame(1, 8'h00, 1'b0);
    check_end("t1", 1'b1, 1);

    // 2: full 64-word frame, back-to-back bytes
    do_reset();
    for (int k = 0; k < 64; k++) words[k] = 32'(k);
    we_count = 0;
    chk_gap = 1'b1;
    send_frame(64, 8'h00, 1'b0);
    chk_gap = 1'b0;
    check_end("t2", 1'b1, 64);

    // 3: bad checksum (07 instead of 06)
    do_reset();
    words[0] = 32'h00100513;
    we_count = 0;
    send_frame(1, 8'h01, 1'b0);
    check_end("t3", 1'b0, 1);

    // 4a: zero count
    do_reset();
    we_count = 0;
    send_byte(8'hA5);
    send_byte(8'h00);
    check_end("t4a", 1'b0, 0);

    // 4b: count above depth
    do_reset();
    we_count = 0;
    send_byte(8'hA5);
    send_byte(8'h41);
    check_end("t4b", 1'b0, 0);

    // 4c: count exactly at depth is accepted (still in DATA, no error)
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h40);
    idle(1);
    chk("t4c_err", {31'd0, w_err}, 32'd0);
    chk("t4c_ready", {31'd0, w_rx_ready}, 32'd1);

    // 5: garbage bytes, then frame 1 with random valid gaps
    do_reset();
    we_count = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    words[0] = 32'h00100513;
    send_frame(1, 8'h00, 1'b1);
    check_end("t5", 1'b1, 1);

    // 6: reset after two data bytes, then a full good frame
    do_reset();
    we_count = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h13);
    send_byte(8'h05);
    w_rst = 1'b1;
    idle(1);
    check_reset_values();
    w_rst = 1'b0;
    idle(3);
    chk("t6_no_partial_we", we_count, 32'd0);
    words[0] = 32'hDEADBEEF;
    words[1] = 32'hA5A5A5A5;
    send_frame(2, 8'h00, 1'b0);
    check_end("t6", 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
